// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL gain scheduler: FSM encoding,
// saturating magnitude and counter ceiling.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    SETTLE  = 2'd2,
    TRACK   = 2'd3
  } pll_state_t;

  // Counters up to 32 bits wide slice their all-ones ceiling from here.
  localparam logic [31:0] CNT_SAT_ALL = 32'hFFFF_FFFF;

  // |e| for a w-bit signed value (sign-extended to 32 bits); the most
  // negative code saturates to the largest positive magnitude.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] e,
                                          input int unsigned         w);
    logic [31:0] mag_max;
    mag_max = (32'd1 << (w - 32'd1)) - 32'd1;
    if (e < -$signed(mag_max)) begin
      abs_sat = mag_max;
    end else if (e < 32'sd0) begin
      abs_sat = 32'(-e);
    end else begin
      abs_sat = 32'(e);
    end
  endfunction

endpackage

// File: rtl/err_window_counter.sv
// Consecutive-sample window counter: compares |error| against a threshold and
// counts back-to-back hits, flagging the sample that reaches the configured count.
module err_window_counter
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned ERR_SIZE      = 16,
  parameter int unsigned CNT_SIZE      = 8,
  parameter bit          COUNT_OUTSIDE = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       enable_i,
  input  logic signed [ERR_SIZE-1:0] error_i,
  input  logic                       valid_i,
  input  logic        [ERR_SIZE-2:0] thresh_i,
  input  logic        [CNT_SIZE-1:0] count_cfg_i,
  output logic                       reached_o
);

  localparam logic [CNT_SIZE-1:0] SAT_MAX = CNT_SAT_ALL[CNT_SIZE-1:0];

  logic [ERR_SIZE-2:0] abs_err_s;
  logic                hit_s;
  logic [CNT_SIZE-1:0] cnt_inc_s;
  logic [CNT_SIZE-1:0] cfg_eff_s;
  logic [CNT_SIZE-1:0] cnt_d;
  logic [CNT_SIZE-1:0] cnt_q;

  always_comb begin
    abs_err_s = (ERR_SIZE-1)'(abs_sat(32'(error_i), ERR_SIZE));
    if (COUNT_OUTSIDE) begin
      hit_s = abs_err_s > thresh_i;
    end else begin
      hit_s = abs_err_s <= thresh_i;
    end
    cnt_inc_s = (cnt_q == SAT_MAX) ? cnt_q : cnt_q + CNT_SIZE'(1);
    cfg_eff_s = (count_cfg_i == '0) ? CNT_SIZE'(1) : count_cfg_i;
    reached_o = enable_i && valid_i && hit_s && (cnt_inc_s >= cfg_eff_s);

    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && valid_i) begin
      cnt_d = hit_s ? cnt_inc_s : '0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pll_gain_scheduler.sv
// PLL loop-filter sequencer: walks IDLE/ACQUIRE/SETTLE/TRACK, switches the
// Kp/Ki pair at the transitions and reports lock / loss of lock.
module pll_gain_scheduler
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned ERR_SIZE       = 16,
  parameter int unsigned K_INT_SIZE     = 8,
  parameter int unsigned K_FRAC_SIZE    = 8,
  parameter int unsigned CNT_SIZE       = 8,
  parameter int unsigned SETTLE_SAMPLES = 16,
  localparam int unsigned KW            = K_INT_SIZE + K_FRAC_SIZE
) (
  input  logic                       clk_ref,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic signed [ERR_SIZE-1:0] error,
  input  logic                       error_valid,
  input  logic signed [KW-1:0]       kp_acq,
  input  logic signed [KW-1:0]       ki_acq,
  input  logic signed [KW-1:0]       kp_trk,
  input  logic signed [KW-1:0]       ki_trk,
  input  logic        [ERR_SIZE-2:0] lock_thresh,
  input  logic        [ERR_SIZE-2:0] unlock_thresh,
  input  logic        [CNT_SIZE-1:0] lock_count,
  input  logic        [CNT_SIZE-1:0] unlock_count,
  output logic                       lf_enable,
  output logic signed [KW-1:0]       Kp,
  output logic signed [KW-1:0]       Ki,
  output logic                       locked,
  output logic                       lock_lost,
  output logic        [1:0]          state
);

  localparam int unsigned SW = $clog2(SETTLE_SAMPLES + 1);

  pll_state_t          state_q;
  logic signed [KW-1:0] kp_q;
  logic signed [KW-1:0] ki_q;
  logic                locked_q;
  logic                lock_lost_q;
  logic [SW-1:0]       settle_q;
  logic                lock_reached_s;
  logic                unlock_reached_s;
  logic                lock_clear_s;
  logic                unlock_clear_s;

  // Counters only run in their own state, so leaving it discards partial counts.
  always_comb begin
    lock_clear_s   = stop || (state_q != ACQUIRE);
    unlock_clear_s = stop || (state_q != TRACK);
  end

  err_window_counter #(
    .ERR_SIZE     (ERR_SIZE),
    .CNT_SIZE     (CNT_SIZE),
    .COUNT_OUTSIDE(1'b0)
  ) u_lock_cnt (
    .clk_i      (clk_ref),
    .rst_i      (rst),
    .clear_i    (lock_clear_s),
    .enable_i   (state_q == ACQUIRE),
    .error_i    (error),
    .valid_i    (error_valid),
    .thresh_i   (lock_thresh),
    .count_cfg_i(lock_count),
    .reached_o  (lock_reached_s)
  );

  err_window_counter #(
    .ERR_SIZE     (ERR_SIZE),
    .CNT_SIZE     (CNT_SIZE),
    .COUNT_OUTSIDE(1'b1)
  ) u_unlock_cnt (
    .clk_i      (clk_ref),
    .rst_i      (rst),
    .clear_i    (unlock_clear_s),
    .enable_i   (state_q == TRACK),
    .error_i    (error),
    .valid_i    (error_valid),
    .thresh_i   (unlock_thresh),
    .count_cfg_i(unlock_count),
    .reached_o  (unlock_reached_s)
  );

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q     <= IDLE;
      kp_q        <= kp_acq;
      ki_q        <= ki_acq;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      settle_q    <= '0;
    end else if (stop) begin
      state_q     <= IDLE;
      kp_q        <= kp_acq;
      ki_q        <= ki_acq;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      settle_q    <= '0;
    end else begin
      lock_lost_q <= 1'b0;
      case (state_q)
        IDLE: begin
          kp_q <= kp_acq;
          ki_q <= ki_acq;
          if (start) begin
            state_q <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (lock_reached_s) begin
            state_q  <= SETTLE;
            kp_q     <= kp_trk;
            ki_q     <= ki_trk;
            settle_q <= '0;
          end
        end
        SETTLE: begin
          if (error_valid) begin
            if (settle_q == SW'(SETTLE_SAMPLES - 1)) begin
              state_q  <= TRACK;
              locked_q <= 1'b1;
            end else begin
              settle_q <= settle_q + SW'(1);
            end
          end
        end
        TRACK: begin
          if (unlock_reached_s) begin
            state_q     <= ACQUIRE;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b1;
            kp_q        <= kp_acq;
            ki_q        <= ki_acq;
          end
        end
        default: begin
          state_q  <= IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // The filter consumes the error on the same edge it is presented.
  assign lf_enable = error_valid && (state_q != IDLE);
  assign Kp        = kp_q;
  assign Ki        = ki_q;
  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_gain_scheduler.sv
// Directed bench for pll_gain_scheduler: lock sequence, window clearing,
// loss of lock, sample gaps, stop/reset priority and magnitude saturation.
module tb_pll_gain_scheduler;

  logic               clk_ref = 1'b0;
  logic               rst, start, stop, error_valid;
  logic signed [15:0] error;
  logic signed [15:0] kp_acq, ki_acq, kp_trk, ki_trk;
  logic        [14:0] lock_thresh, unlock_thresh;
  logic        [7:0]  lock_count, unlock_count;
  logic               lf_enable, locked, lock_lost;
  logic signed [15:0] Kp, Ki;
  logic        [1:0]  state;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [15:0] KP_A = 16'h0100, KI_A = 16'h0020;
  localparam logic [15:0] KP_T = 16'h0080, KI_T = 16'h0008;

  pll_gain_scheduler dut (
    .clk_ref(clk_ref), .rst(rst), .start(start), .stop(stop),
    .error(error), .error_valid(error_valid),
    .kp_acq(kp_acq), .ki_acq(ki_acq), .kp_trk(kp_trk), .ki_trk(ki_trk),
    .lock_thresh(lock_thresh), .unlock_thresh(unlock_thresh),
    .lock_count(lock_count), .unlock_count(unlock_count),
    .lf_enable(lf_enable), .Kp(Kp), .Ki(Ki), .locked(locked),
    .lock_lost(lock_lost), .state(state)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic cycle(input logic v, input logic signed [15:0] e);
    error_valid = v;
    error       = e;
    @(posedge clk_ref);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    kp_acq = KP_A; ki_acq = KI_A; kp_trk = KP_T; ki_trk = KI_T;
    lock_thresh = 15'd100; unlock_thresh = 15'd500;
    lock_count = 8'd4; unlock_count = 8'd3;
    cycle(1'b1, 16'sd50);
    cycle(1'b1, 16'sd50);
    total_cnt++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else pass_cnt++;
    total_cnt++; if (Kp !== KP_A || Ki !== KI_A) $display("FAIL reset_gains got=%h/%h exp=%h/%h", Kp, Ki, KP_A, KI_A); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0 || lock_lost !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", locked, lock_lost); else pass_cnt++;
    total_cnt++; if (lf_enable !== 1'b0) $display("FAIL reset_lf_enable got=%b exp=0", lf_enable); else pass_cnt++;
    rst = 1'b0;
    cycle(1'b0, 16'sd0);
  endtask

  task automatic test_lock_sequence;
    start = 1'b1;
    cycle(1'b0, 16'sd0);
    start = 1'b0;
    total_cnt++; if (state !== 2'd1) $display("FAIL start_acquire got=%0d exp=1", state); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      error_valid = 1'b1; error = 16'sd50; #1;
      total_cnt++; if (lf_enable !== 1'b1) $display("FAIL acq_lf_enable sample=%0d got=%b exp=1", i, lf_enable); else pass_cnt++;
      cycle(1'b1, 16'sd50);
      total_cnt++; if (state !== ((i == 4) ? 2'd2 : 2'd1)) $display("FAIL acq_state sample=%0d got=%0d", i, state); else pass_cnt++;
    end
    total_cnt++; if (Kp !== KP_T || Ki !== KI_T) $display("FAIL settle_gains got=%h/%h exp=%h/%h", Kp, Ki, KP_T, KI_T); else pass_cnt++;
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 16'sd1000);
      if (i == 15) begin
        total_cnt++; if (state !== 2'd2 || locked !== 1'b0) $display("FAIL settle_hold got=%0d locked=%b exp=2/0", state, locked); else pass_cnt++;
      end
    end
    total_cnt++; if (state !== 2'd3 || locked !== 1'b1) $display("FAIL track_lock got=%0d locked=%b exp=3/1", state, locked); else pass_cnt++;
  endtask

  task automatic test_unlock;
    logic signed [15:0] seq [6];
    seq = '{16'sd600, 16'sd600, 16'sd400, 16'sd600, 16'sd600, 16'sd600};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, seq[i]);
      total_cnt++; if (state !== 2'd3 || lock_lost !== 1'b0) $display("FAIL unlock_early sample=%0d got=%0d lost=%b exp=3/0", i + 1, state, lock_lost); else pass_cnt++;
    end
    cycle(1'b1, seq[5]);
    total_cnt++; if (state !== 2'd1 || lock_lost !== 1'b1 || locked !== 1'b0) $display("FAIL unlock_fire got=%0d lost=%b locked=%b exp=1/1/0", state, lock_lost, locked); else pass_cnt++;
    total_cnt++; if (Kp !== KP_A || Ki !== KI_A) $display("FAIL unlock_gains got=%h/%h exp=%h/%h", Kp, Ki, KP_A, KI_A); else pass_cnt++;
    cycle(1'b0, 16'sd0);
    total_cnt++; if (lock_lost !== 1'b0) $display("FAIL lost_pulse_width got=%b exp=0", lock_lost); else pass_cnt++;
  endtask

  task automatic test_gap_and_min_neg;
    cycle(1'b1, 16'sd50); cycle(1'b1, 16'sd50); cycle(1'b1, 16'sd50);
    cycle(1'b1, -16'sd32768);
    cycle(1'b1, 16'sd50); cycle(1'b1, 16'sd50); cycle(1'b1, 16'sd50);
    total_cnt++; if (state !== 2'd1) $display("FAIL min_neg_clear got=%0d exp=1", state); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      error_valid = 1'b0; error = 16'sd50; #1;
      total_cnt++; if (lf_enable !== 1'b0) $display("FAIL gap_lf_enable cycle=%0d got=%b exp=0", i, lf_enable); else pass_cnt++;
      cycle(1'b0, 16'sd50);
    end
    total_cnt++; if (state !== 2'd1) $display("FAIL gap_state got=%0d exp=1", state); else pass_cnt++;
    cycle(1'b1, 16'sd50);
    total_cnt++; if (state !== 2'd2) $display("FAIL gap_count_held got=%0d exp=2", state); else pass_cnt++;
  endtask

  task automatic test_window_clear;
    logic signed [15:0] seq [8];
    seq = '{16'sd100, -16'sd100, 16'sd50, 16'sd200, 16'sd50, 16'sd50, 16'sd50, 16'sd50};
    stop = 1'b1; cycle(1'b0, 16'sd0); stop = 1'b0;
    start = 1'b1; cycle(1'b0, 16'sd0); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, seq[i]);
      total_cnt++; if (state !== ((i == 7) ? 2'd2 : 2'd1)) $display("FAIL window_clear sample=%0d got=%0d", i + 1, state); else pass_cnt++;
    end
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'sd0);
    total_cnt++; if (state !== 2'd3) $display("FAIL relock got=%0d exp=3", state); else pass_cnt++;
  endtask

  task automatic test_stop_priority;
    cycle(1'b1, 16'sd600); cycle(1'b1, 16'sd600);
    stop = 1'b1;
    cycle(1'b1, 16'sd600);
    stop = 1'b0;
    total_cnt++; if (state !== 2'd0 || lock_lost !== 1'b0 || locked !== 1'b0) $display("FAIL stop_vs_unlock got=%0d lost=%b locked=%b exp=0/0/0", state, lock_lost, locked); else pass_cnt++;
    total_cnt++; if (Kp !== KP_A) $display("FAIL stop_gains got=%h exp=%h", Kp, KP_A); else pass_cnt++;
    error_valid = 1'b1; #1;
    total_cnt++; if (lf_enable !== 1'b0) $display("FAIL stop_lf_enable got=%b exp=0", lf_enable); else pass_cnt++;
    start = 1'b1; stop = 1'b1;
    cycle(1'b1, 16'sd50);
    start = 1'b0; stop = 1'b0;
    total_cnt++; if (state !== 2'd0) $display("FAIL start_stop_idle got=%0d exp=0", state); else pass_cnt++;
  endtask

  task automatic test_reset_mid_settle;
    start = 1'b1; cycle(1'b0, 16'sd0); start = 1'b0;
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'sd50);
    total_cnt++; if (state !== 2'd2) $display("FAIL pre_reset_settle got=%0d exp=2", state); else pass_cnt++;
    rst = 1'b1;
    cycle(1'b1, 16'sd50);
    rst = 1'b0;
    total_cnt++; if (state !== 2'd0 || locked !== 1'b0 || lf_enable !== 1'b0) $display("FAIL mid_reset got=%0d locked=%b lf=%b exp=0/0/0", state, locked, lf_enable); else pass_cnt++;
    total_cnt++; if (Kp !== KP_A || Ki !== KI_A) $display("FAIL mid_reset_gains got=%h/%h exp=%h/%h", Kp, Ki, KP_A, KI_A); else pass_cnt++;
  endtask

  task automatic test_zero_count_and_sat;
    lock_count = 8'd0; unlock_count = 8'd1; unlock_thresh = 15'd32766;
    cycle(1'b0, 16'sd0);
    start = 1'b1; cycle(1'b0, 16'sd0); start = 1'b0;
    cycle(1'b1, 16'sd50);
    total_cnt++; if (state !== 2'd2) $display("FAIL zero_lock_count got=%0d exp=2", state); else pass_cnt++;
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'sd50);
    cycle(1'b1, -16'sd32766);
    total_cnt++; if (state !== 2'd3 || lock_lost !== 1'b0) $display("FAIL sat_below got=%0d lost=%b exp=3/0", state, lock_lost); else pass_cnt++;
    cycle(1'b1, -16'sd32768);
    total_cnt++; if (state !== 2'd1 || lock_lost !== 1'b1) $display("FAIL sat_min_neg got=%0d lost=%b exp=1/1", state, lock_lost); else pass_cnt++;
  endtask

  initial begin
    error = 16'sd0; error_valid = 1'b0;
    test_reset;
    test_lock_sequence;
    test_unlock;
    test_gap_and_min_neg;
    test_window_clear;
    test_stop_priority;
    test_reset_mid_settle;
    test_zero_count_and_sat;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pll_gain_scheduler.md
Name: pll_gain_scheduler

Overview:
- Sequences the PLL loop filter through acquisition, settle and tracking.
- Drives the filter's enable strobe and selects the Kp/Ki gain pair from phase-error magnitude history.
- Reports lock status.
- Sits between the phase detector (error plus valid strobe) and the loop filter (enable, Kp, Ki).

Parameters:
- ERR_SIZE, 16, phase-error width, signed.
- K_INT_SIZE, 8, gain integer bits.
- K_FRAC_SIZE, 8, gain fractional bits; gain width KW = K_INT_SIZE+K_FRAC_SIZE.
- CNT_SIZE, 8, width of lock/unlock sample counters and count configs.
- SETTLE_SAMPLES, 16, error_valid samples spent in SETTLE, ≥1.

Ports:
- clk_ref  in  1  reference clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins acquisition from IDLE.
- stop  in  1  level or pulse; forces IDLE.
- error  in  ERR_SIZE  signed phase error.
- error_valid  in  1  error is valid this cycle.
- kp_acq, ki_acq  in  KW each  acquisition gains, signed.
- kp_trk, ki_trk  in  KW each  tracking gains, signed.
- lock_thresh  in  ERR_SIZE-1  unsigned |error| bound for a lock sample.
- unlock_thresh  in  ERR_SIZE-1  unsigned |error| bound for a loss sample.
- lock_count  in  CNT_SIZE  consecutive in-window samples to declare lock.
- unlock_count  in  CNT_SIZE  consecutive out-of-window samples to declare loss.
- lf_enable  out  1  enable to loop filter.
- Kp, Ki  out  KW each  registered gains to loop filter.
- locked  out  1  registered lock flag.
- lock_lost  out  1  one-cycle pulse on TRACK→ACQUIRE.
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, Kp=kp_acq, Ki=ki_acq as sampled that edge, locked=0, lock_lost=0, both counters=0. lf_enable=0 because it is combinational from state. rst has priority over all other inputs.
- Encoding: IDLE=0, ACQUIRE=1, SETTLE=2, TRACK=3.
- lf_enable = error_valid && state!=IDLE. This is combinational, so the filter consumes the error on the same edge. Zero added latency.
- abs_err = |error|, with -2^(ERR_SIZE-1) saturating to 2^(ERR_SIZE-1)-1.
- in_win = abs_err <= lock_thresh; out_win = abs_err > unlock_thresh.
- A count config of 0 is treated as 1. Counters saturate at all-ones and never wrap.
- stop=1 (and rst=0): next state IDLE, locked←0, counters←0, Kp/Ki←acq. stop beats start and every other transition.
- IDLE:
  - Kp/Ki track the acq inputs each cycle.
  - start → ACQUIRE. lock_cnt←0.
- ACQUIRE, on each error_valid:
  - in_win → lock_cnt+1; otherwise lock_cnt←0.
  - When the incremented value reaches lock_count → SETTLE on that edge. Kp←kp_trk, Ki←ki_trk, settle_cnt←0.
  - Cycles without error_valid leave counters unchanged.
- SETTLE:
  - Each error_valid increments settle_cnt, regardless of error value.
  - On the SETTLE_SAMPLES-th sample → TRACK, locked←1, unlock_cnt←0.
  - The first filter update after leaving ACQUIRE already uses trk gains, because gain registers update on the transition edge.
- TRACK, on each error_valid:
  - out_win → unlock_cnt+1; otherwise unlock_cnt←0.
  - Reaching unlock_count → ACQUIRE. locked←0, lock_lost←1 for exactly one cycle, Kp/Ki←acq, lock_cnt←0.
- start outside IDLE: ignored.
- Config inputs must be static outside IDLE, except that gains are re-sampled only at the transitions above.
- Reset or stop mid-SETTLE/TRACK: lf_enable drops the next cycle. No partial counts are retained.

Decomposition:
- Package pll_ctrl_pkg holds:
  - state enum pll_state_t (IDLE/ACQUIRE/SETTLE/TRACK).
  - abs_sat function.
  - localparam for the saturating-counter maximum.
- One sub-module, err_window_counter: abs/compare plus saturating consecutive-hit counter, with clear and threshold-reached output. Instantiated twice, once for lock and once for unlock.

Test Plan:
- Reset then start, with lock_count=4, lock_thresh=100, error=50 valid every cycle → ACQUIRE, SETTLE on the 4th valid, Kp=kp_trk on the next cycle, TRACK with locked=1 after 16 more valids (SETTLE_SAMPLES=16).
- ACQUIRE with errors 50,50,50,200,50,50,50,50 (lock_count=4) → counter clears at 200, SETTLE only after the 8th sample. Error -32768 is treated as |error|=32767, which is not in window.
- TRACK with unlock_count=3, unlock_thresh=500, errors 600,600,400,600,600,600 → lock_lost pulses once, after the 6th sample only. locked=0, Kp=kp_acq, state=ACQUIRE.
- error_valid low for 10 cycles mid-ACQUIRE → lf_enable=0 throughout, lock_cnt held. Gaps do not reset the count.
- stop asserted in TRACK simultaneously with an unlock-triggering sample → IDLE next cycle, no lock_lost pulse, locked=0. Also check start+stop together in IDLE → stays IDLE.
- rst asserted mid-SETTLE → next cycle state=0, locked=0, lf_enable=0, Kp/Ki=acq values. lock_count=0 then locks after 1 sample.
